// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I control path.
//   - RV32I major opcode constants
//   - 4-bit FSM state encoding
//   - ALU-op codes consumed by the ALU control decoder
//   - datapath mux select encodings (alu_src_a/b, pc_source, mem_to_reg)
//   - ctrl_t: bundle of every control output, so it can be decoded once and gated as a whole
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_MA, S_MR, S_MW, S_WB_ALU,
    S_WB_MEM, S_BR, S_JAL, S_JALR, S_LUI, S_AUIPC, S_ILL
  } state_e;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_ZERO   = 2'b10;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       instr_retired;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: free-running cycle counter and retired-instruction counter.
// Both wrap modulo 2^CNT_W. Only exists when CTRL_PERF_EN is defined; the
// body is guarded so a default build carries no stray top-level module.
//   clk, rstn     : clock, async active-low reset
//   retire        : one-cycle pulse per completed instruction
//   cycle_cnt     : cycles since reset release
//   instret_cnt   : retired instructions since reset release
`ifdef CTRL_PERF_EN
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
`endif

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle RV32I core.
// Sequences the shared ALU, memory port and register file through
// fetch/decode/execute/memory/write-back. Outputs are Moore decodes of the
// state, plus mem_ready in IF (ir_write/pc_write) and MW (instr_retired).
// Optional feature macro: CTRL_PERF_EN (cycle/instret performance counters;
// without it both counter ports are tied to zero).
//   clk, rstn          : clock, async active-low reset (forces all outputs 0)
//   opcode             : IR[6:0]
//   br_cond            : branch condition from datapath (qualification done there)
//   mem_ready          : memory access completes this cycle
//   mem_read/mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
//   alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg : datapath controls
//   instr_retired      : retire pulse; illegal : sticky unknown-opcode flag
//   cycle_cnt, instret_cnt : performance counters
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       opcode,
  input  logic             br_cond,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             instr_retired,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_o;

  // The branch decision is applied by the datapath through pc_write_cond.
  logic unused_br_cond;
  assign unused_br_cond = br_cond;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_ALU;
          state_d        = S_ID;
        end
      end
      S_ID: begin
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_R:               state_d = S_EX_R;
          OP_I:               state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_MA;
          OP_BRANCH:          state_d = S_BR;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          default:            state_d = S_ILL;
        endcase
      end
      S_EX_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_RTYPE;
        state_d        = S_WB_ALU;
      end
      S_EX_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ITYPE;
        state_d        = S_WB_ALU;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = S_WB_ALU;
      end
      S_AUIPC: begin
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = S_WB_ALU;
      end
      S_MA: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = (opcode == OP_STORE) ? S_MW : S_MR;
      end
      S_MR: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MW: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          ctrl.instr_retired = 1'b1;
          state_d            = S_IF;
        end
      end
      S_WB_ALU: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = M2R_ALUOUT;
        ctrl.instr_retired = 1'b1;
        state_d            = S_IF;
      end
      S_WB_MEM: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = M2R_MDR;
        ctrl.instr_retired = 1'b1;
        state_d            = S_IF;
      end
      S_BR: begin
        ctrl.alu_src_a     = SRC_A_RS1;
        ctrl.alu_src_b     = SRC_B_RS2;
        ctrl.alu_op        = ALU_BRANCH;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.instr_retired = 1'b1;
        state_d            = S_IF;
      end
      S_JAL: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = M2R_PC;
        ctrl.pc_write      = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.instr_retired = 1'b1;
        state_d            = S_IF;
      end
      S_JALR: begin
        ctrl.alu_src_a     = SRC_A_RS1;
        ctrl.alu_src_b     = SRC_B_IMM;
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = M2R_PC;
        ctrl.pc_write      = 1'b1;
        ctrl.pc_source     = PC_SRC_ALU;
        ctrl.instr_retired = 1'b1;
        state_d            = S_IF;
      end
      S_ILL: begin
        ctrl.illegal = 1'b1;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset forces every control output low combinationally, so a pending
  // memory access is dropped the moment rstn falls, not at the next edge.
  assign ctrl_o = rstn ? ctrl : '0;

  assign mem_read      = ctrl_o.mem_read;
  assign mem_write     = ctrl_o.mem_write;
  assign i_or_d        = ctrl_o.i_or_d;
  assign ir_write      = ctrl_o.ir_write;
  assign pc_write      = ctrl_o.pc_write;
  assign pc_write_cond = ctrl_o.pc_write_cond;
  assign pc_source     = ctrl_o.pc_source;
  assign alu_op        = ctrl_o.alu_op;
  assign alu_src_a     = ctrl_o.alu_src_a;
  assign alu_src_b     = ctrl_o.alu_src_b;
  assign reg_write     = ctrl_o.reg_write;
  assign mem_to_reg    = ctrl_o.mem_to_reg;
  assign instr_retired = ctrl_o.instr_retired;
  assign illegal       = ctrl_o.illegal;

`ifdef CTRL_PERF_EN
  perf_counter #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rstn        (rstn),
    .retire      (instr_retired),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors
// are queued as each instruction is issued and checked cycle by cycle.
module tb_multicycle_control;

  localparam int unsigned TB_CNT_W = 4;

  typedef enum int {
    T_IF, T_ID, T_EXR, T_EXI, T_MA, T_MR, T_MW, T_WBA, T_WBM,
    T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC, T_ILL
  } tst_e;

  logic                clk = 1'b0;
  logic                rstn;
  logic [6:0]          opcode;
  logic                br_cond;
  logic                mem_ready;
  logic                mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]          pc_source, alu_op, alu_src_a, alu_src_b, mem_to_reg;
  logic                reg_write, instr_retired, illegal;
  logic [TB_CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [18:0]         obs;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc_exp = 0;
  int unsigned ret_exp = 0;
  string       cur_tag = "";

  logic [18:0] exp_q[$];
  bit          rdy_q[$];
  bit          brc_q[$];

  multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .br_cond(br_cond), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .instr_retired(instr_retired), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_source, alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg,
                instr_retired, illegal};

  // Expected control vector for a state, straight from the state table.
  function automatic logic [18:0] ev(tst_e s, bit rdy);
    logic mr, mw, iod, irw, pcw, pcwc, rw, ret, ill;
    logic [1:0] pcs, aop, sa, sb, m2r;
    {mr, mw, iod, irw, pcw, pcwc, rw, ret, ill} = '0;
    {pcs, aop, sa, sb, m2r} = '0;
    case (s)
      T_IF:    begin mr = 1; sb = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
      T_ID:    begin sa = 2'b11; sb = 2'b10; end
      T_EXR:   begin sa = 2'b01; sb = 2'b00; aop = 2'b10; end
      T_EXI:   begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
      T_LUI:   begin sa = 2'b10; sb = 2'b10; end
      T_AUIPC: begin sa = 2'b11; sb = 2'b10; end
      T_MA:    begin sa = 2'b01; sb = 2'b10; end
      T_MR:    begin mr = 1; iod = 1; end
      T_MW:    begin mw = 1; iod = 1; ret = rdy; end
      T_WBA:   begin rw = 1; ret = 1; end
      T_WBM:   begin rw = 1; m2r = 2'b01; ret = 1; end
      T_BR:    begin sa = 2'b01; aop = 2'b01; pcwc = 1; pcs = 2'b01; ret = 1; end
      T_JAL:   begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 2'b01; ret = 1; end
      T_JALR:  begin sa = 2'b01; sb = 2'b10; rw = 1; m2r = 2'b10; pcw = 1; ret = 1; end
      T_ILL:   begin ill = 1; end
      default: ;
    endcase
    return {mr, mw, iod, irw, pcw, pcwc, pcs, aop, sa, sb, rw, m2r, ret, ill};
  endfunction

  task automatic push(tst_e s, bit rdy = 1'b1, bit brc = 1'b0);
    exp_q.push_back(ev(s, rdy));
    rdy_q.push_back(rdy);
    brc_q.push_back(brc);
  endtask

  // Inputs change at posedge+1; outputs are sampled at the negedge.
  task automatic drain();
    logic [18:0] e;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      br_cond   = brc_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", cur_tag, cyc_exp, obs, e);
      end
      if (e[1]) ret_exp++;
      @(posedge clk);
      cyc_exp++;
      #1;
    end
  endtask

  task automatic alu_instr(logic [6:0] op, tst_e ex, string tag);
    cur_tag = tag;
    opcode = op;
    push(T_IF); push(T_ID); push(ex); push(T_WBA);
    drain();
  endtask

  task automatic check_cnt(string tag);
    logic [TB_CNT_W-1:0] ec, er;
`ifdef CTRL_PERF_EN
    ec = TB_CNT_W'(cyc_exp);
    er = TB_CNT_W'(ret_exp);
`else
    ec = '0;
    er = '0;
`endif
    checks++;
    assert (cycle_cnt === ec) else begin
      failures++;
      $error("FAIL %s_cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, ec);
    end
    checks++;
    assert (instret_cnt === er) else begin
      failures++;
      $error("FAIL %s_instret_cnt observed=%0d expected=%0d", tag, instret_cnt, er);
    end
  endtask

  task automatic check_zero(string tag);
    checks++;
    assert (obs === 19'd0) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, 19'd0);
    end
  endtask

  task automatic reset_pulse(string tag);
    rstn = 1'b0;
    #1;
    check_zero(tag);
    cyc_exp = 0;
    ret_exp = 0;
    check_cnt(tag);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; opcode = '0; br_cond = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    check_cnt("reset");
    rstn = 1'b1;

    alu_instr(7'b0110011, T_EXR, "add");

    cur_tag = "lw_wait2"; opcode = 7'b0000011;
    push(T_IF); push(T_ID); push(T_MA);
    push(T_MR, 1'b0); push(T_MR, 1'b0); push(T_MR, 1'b1); push(T_WBM);
    drain();

    cur_tag = "sw_if_wait"; opcode = 7'b0100011;
    push(T_IF, 1'b0); push(T_IF); push(T_ID); push(T_MA); push(T_MW);
    drain();

    cur_tag = "beq_nt"; opcode = 7'b1100011;
    push(T_IF); push(T_ID); push(T_BR, 1'b1, 1'b0);
    drain();
    cur_tag = "beq_t";
    push(T_IF); push(T_ID); push(T_BR, 1'b1, 1'b1);
    drain();

    cur_tag = "jal"; opcode = 7'b1101111;
    push(T_IF); push(T_ID); push(T_JAL);
    drain();
    cur_tag = "jalr"; opcode = 7'b1100111;
    push(T_IF); push(T_ID); push(T_JALR);
    drain();

    alu_instr(7'b0110111, T_LUI, "lui");
    alu_instr(7'b0010111, T_AUIPC, "auipc");
    alu_instr(7'b0010011, T_EXI, "addi");
    check_cnt("mix");

    // Ten R-type back to back: 40 cycles, 10 retires (cycle count wraps at CNT_W=4).
    reset_pulse("reset_before_perf");
    for (int i = 0; i < 10; i++) alu_instr(7'b0110011, T_EXR, "add_x10");
    check_cnt("perf10");

    // Reset while a store is waiting in MW.
    cur_tag = "sw_pending"; opcode = 7'b0100011;
    push(T_IF); push(T_ID); push(T_MA); push(T_MW, 1'b0);
    drain();
    mem_ready = 1'b0;
    reset_pulse("reset_in_mw");
    alu_instr(7'b0110011, T_EXR, "add_after_mw_reset");

    // Unknown opcode: ILL is sticky and silent until reset.
    cur_tag = "illegal"; opcode = 7'b0000000;
    push(T_IF); push(T_ID); push(T_ILL); push(T_ILL, 1'b0); push(T_ILL);
    drain();
    check_cnt("ill");
    reset_pulse("reset_from_ill");
    alu_instr(7'b0110011, T_EXR, "add_after_ill");
    check_cnt("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
